axi3_bram_responder: RTL



---
 rtl/axi3_bram_responder_if.sv | 78 +++++++
 rtl/axi3_bram_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_bram_responder_if.sv
// -----------------------------------------------------------------------------
// axi3_bram_responder_if
//
// Purpose : AXI3 32-bit bus bundle (AW/W/B/AR/R channels) between a master and
//           the axi3_bram_responder slave.
// Modports: master - drives valid/payload and the response-channel readies.
//           slave  - drives awready/wready/arready and the B and R channels.
// Clock and reset are not part of the bundle; they stay plain module ports.
// -----------------------------------------------------------------------------
interface axi3_bram_responder_if;

   // Write address channel
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [5:0]  awid;

   // Write data channel
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic [5:0]  wid;

   // Write response channel
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [5:0]  bid;

   // Read address channel
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [5:0]  arid;

   // Read data channel
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [5:0]  rid;
   logic        rlast;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst, awid,
      input  awready,
      output wvalid, wdata, wstrb, wlast, wid,
      input  wready,
      input  bvalid, bresp, bid,
      output bready,
      output arvalid, araddr, arlen, arsize, arburst, arid,
      input  arready,
      input  rvalid, rdata, rresp, rid, rlast,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst, awid,
      output awready,
      input  wvalid, wdata, wstrb, wlast, wid,
      output wready,
      output bvalid, bresp, bid,
      input  bready,
      input  arvalid, araddr, arlen, arsize, arburst, arid,
      output arready,
      output rvalid, rdata, rresp, rid, rlast,
      input  rready
   );

endinterface : axi3_bram_responder_if

// File: rtl/axi3_bram_responder.sv
// -----------------------------------------------------------------------------
// axi3_bram_responder
//
// Purpose : AXI3 slave terminating 32-bit master transactions into a small
//           word-addressed register array. Independent write (AW/W/B) and
//           read (AR/R) FSMs, one outstanding transaction each. Beats outside
//           the array, or with a size other than 4 bytes, answer SLVERR.
//
// Ports   : clock    - sole clock
//           reset_n  - asynchronous active-low reset
//           bus      - axi3_bram_responder_if.slave (all AXI channels)
//
// Params  : DEPTH_WORDS - number of 32-bit words (power of two, 16..4096)
//           BASE_ADDR   - byte address of word 0 (aligned to DEPTH_WORDS*4)
//
// Options : AXI3_WID_CHECK_EN - when defined, a W beat whose wid differs from
//           the latched awid is accepted but not written, and the transaction
//           answers SLVERR. When undefined, wid is ignored.
// -----------------------------------------------------------------------------
module axi3_bram_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic                  clock,
   input logic                  reset_n,
   axi3_bram_responder_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   // Addresses are carried with a 33rd bit so an INCR burst running past
   // 0xFFFF_FFFC cannot wrap back into the array window.
   localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(DEPTH_WORDS * 4);

   localparam logic [2:0] SIZE_WORD   = 3'b010;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write FSM encoding
   localparam logic [1:0] W_INIT = 2'd0;
   localparam logic [1:0] W_IDLE = 2'd1;
   localparam logic [1:0] W_DATA = 2'd2;
   localparam logic [1:0] W_RESP = 2'd3;

   // Read FSM encoding
   localparam logic [1:0] R_INIT  = 2'd0;
   localparam logic [1:0] R_IDLE  = 2'd1;
   localparam logic [1:0] R_FETCH = 2'd2;
   localparam logic [1:0] R_DATA  = 2'd3;

   logic [31:0] mem [DEPTH_WORDS];

   // ---------------------------------------------------------------------------
   // Write path state
   // ---------------------------------------------------------------------------
   logic [1:0]  wstate_q,   wstate_d;
   logic [32:0] waddr_q,    waddr_d;
   logic [3:0]  wlen_q,     wlen_d;
   logic        wfixed_q,   wfixed_d;
   logic [5:0]  awid_q,     awid_d;
   logic        wsize_ok_q, wsize_ok_d;
   logic        werr_q,     werr_d;
   logic [3:0]  wbeat_q,    wbeat_d;

   logic             mem_we;
   logic             w_in_range;
   logic             wid_ok;
   logic             w_beat_err;
   logic             w_is_last;
   logic [IDX_W-1:0] w_idx;

   assign w_in_range = (waddr_q >= LO_ADDR) && (waddr_q < HI_ADDR);
   // BASE_ADDR is aligned to the array size, so the low address bits are the
   // word index directly.
   assign w_idx      = waddr_q[IDX_W+1:2];
   assign w_is_last  = (wbeat_q == wlen_q);

`ifdef AXI3_WID_CHECK_EN
   assign wid_ok = (bus.wid == awid_q);
`else
   assign wid_ok = 1'b1;
`endif

   assign w_beat_err = !wsize_ok_q || !w_in_range || !wid_ok;

   // NOTE: every signal assigned in an always_comb gets a default at the top,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      wstate_d   = wstate_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wfixed_d   = wfixed_q;
      awid_d     = awid_q;
      wsize_ok_d = wsize_ok_q;
      werr_d     = werr_q;
      wbeat_d    = wbeat_q;
      mem_we     = 1'b0;

      case (wstate_q)
         W_INIT: wstate_d = W_IDLE;

         W_IDLE: begin
            if (bus.awvalid) begin
               waddr_d    = {1'b0, bus.awaddr};
               wlen_d     = bus.awlen;
               wfixed_d   = (bus.awburst == BURST_FIXED);
               awid_d     = bus.awid;
               wsize_ok_d = (bus.awsize == SIZE_WORD);
               werr_d     = 1'b0;
               wbeat_d    = 4'd0;
               wstate_d   = W_DATA;
            end
         end

         W_DATA: begin
            if (bus.wvalid) begin
               if (w_beat_err) begin
                  werr_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
               end
               // wlast has to land exactly on the final beat of the burst.
               if (bus.wlast != w_is_last) begin
                  werr_d = 1'b1;
               end
               if (bus.wlast || w_is_last) begin
                  wstate_d = W_RESP;
               end else begin
                  wbeat_d = wbeat_q + 4'd1;
                  if (!wfixed_q) begin
                     waddr_d = waddr_q + 33'd4;
                  end
               end
            end
         end

         W_RESP: begin
            if (bus.bready) begin
               wstate_d = W_IDLE;
            end
         end

         default: wstate_d = W_INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wstate_q   <= W_INIT;
         waddr_q    <= '0;
         wlen_q     <= '0;
         wfixed_q   <= 1'b0;
         awid_q     <= '0;
         wsize_ok_q <= 1'b0;
         werr_q     <= 1'b0;
         wbeat_q    <= '0;
      end else begin
         wstate_q   <= wstate_d;
         waddr_q    <= waddr_d;
         wlen_q     <= wlen_d;
         wfixed_q   <= wfixed_d;
         awid_q     <= awid_d;
         wsize_ok_q <= wsize_ok_d;
         werr_q     <= werr_d;
         wbeat_q    <= wbeat_d;
      end
   end

   // NOTE: the array has no reset; its contents survive reset_n, and a reset
   // branch here would turn the RAM into thousands of resettable flops.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) begin
               mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.awready = (wstate_q == W_IDLE);
   assign bus.wready  = (wstate_q == W_DATA);
   assign bus.bvalid  = (wstate_q == W_RESP);
   assign bus.bresp   = ((wstate_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
   assign bus.bid     = awid_q;

   // ---------------------------------------------------------------------------
   // Read path state
   // ---------------------------------------------------------------------------
   logic [1:0]  rstate_q,   rstate_d;
   logic [32:0] raddr_q,    raddr_d;
   logic [3:0]  rlen_q,     rlen_d;
   logic        rfixed_q,   rfixed_d;
   logic [5:0]  arid_q,     arid_d;
   logic        rsize_ok_q, rsize_ok_d;
   logic [3:0]  rbeat_q,    rbeat_d;
   logic [31:0] rdata_q,    rdata_d;
   logic [1:0]  rresp_q,    rresp_d;

   logic             r_ok;
   logic [IDX_W-1:0] r_idx;

   assign r_ok  = rsize_ok_q && (raddr_q >= LO_ADDR) && (raddr_q < HI_ADDR);
   assign r_idx = raddr_q[IDX_W+1:2];

   always_comb begin
      rstate_d   = rstate_q;
      raddr_d    = raddr_q;
      rlen_d     = rlen_q;
      rfixed_d   = rfixed_q;
      arid_d     = arid_q;
      rsize_ok_d = rsize_ok_q;
      rbeat_d    = rbeat_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;

      case (rstate_q)
         R_INIT: rstate_d = R_IDLE;

         R_IDLE: begin
            if (bus.arvalid) begin
               raddr_d    = {1'b0, bus.araddr};
               rlen_d     = bus.arlen;
               rfixed_d   = (bus.arburst == BURST_FIXED);
               arid_d     = bus.arid;
               rsize_ok_d = (bus.arsize == SIZE_WORD);
               rbeat_d    = 4'd0;
               rstate_d   = R_FETCH;
            end
         end

         // The array value is captured into rdata_q on the same edge a write
         // may update that word, so a colliding read sees the old contents.
         R_FETCH: begin
            rdata_d  = r_ok ? mem[r_idx] : 32'd0;
            rresp_d  = r_ok ? RESP_OKAY : RESP_SLVERR;
            rstate_d = R_DATA;
         end

         R_DATA: begin
            if (bus.rready) begin
               if (rbeat_q == rlen_q) begin
                  rstate_d = R_IDLE;
               end else begin
                  rbeat_d  = rbeat_q + 4'd1;
                  rstate_d = R_FETCH;
                  if (!rfixed_q) begin
                     raddr_d = raddr_q + 33'd4;
                  end
               end
            end
         end

         default: rstate_d = R_INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rstate_q   <= R_INIT;
         raddr_q    <= '0;
         rlen_q     <= '0;
         rfixed_q   <= 1'b0;
         arid_q     <= '0;
         rsize_ok_q <= 1'b0;
         rbeat_q    <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         rstate_q   <= rstate_d;
         raddr_q    <= raddr_d;
         rlen_q     <= rlen_d;
         rfixed_q   <= rfixed_d;
         arid_q     <= arid_d;
         rsize_ok_q <= rsize_ok_d;
         rbeat_q    <= rbeat_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign bus.arready = (rstate_q == R_IDLE);
   assign bus.rvalid  = (rstate_q == R_DATA);
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign bus.rid     = arid_q;
   assign bus.rlast   = (rstate_q == R_DATA) && (rbeat_q == rlen_q);

endmodule : axi3_bram_responder
